// File: rtl/store_sequencer.sv
// Store sequencer: issues word stores directly and builds byte/half stores
// with a read-modify-write of the containing aligned word.
module store_sequencer (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [1:0]  size,
   input  logic [31:0] addr,
   input  logic [31:0] data,
   input  logic [31:0] mem_rdata,
   output logic [31:0] mem_addr,
   output logic        mem_wr,
   output logic [31:0] mem_wdata,
   output logic        busy,
   output logic        done,
   output logic        misaligned
);

   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;

   typedef enum logic [2:0] {IDLE, RD_ADDR, RD_WAIT, WRITE, DONE} state_t;

   state_t          state, state_n;
   logic [1:0]      off_q;
   logic            half_q;
   logic [DW-1:0]   data_q;
   logic            load_c;
   logic            aligned_c;
   logic [AW-1:0]   mem_addr_n;
   logic [DW-1:0]   mem_wdata_n;
   logic            mem_wr_n, done_n, misaligned_n;

   // Replace the addressed lane(s) of base with the low bits of src.
   function automatic logic [DW-1:0] merge(input logic [DW-1:0] base,
                                           input logic [DW-1:0] src,
                                           input logic [1:0]    off,
                                           input logic          half);
      logic [DW-1:0] mask;
      logic [4:0]    sh;
      sh   = {off, 3'b000};
      mask = half ? (DW'(32'h0000_FFFF) << sh) : (DW'(32'h0000_00FF) << sh);
      return (base & ~mask) | ((src << sh) & mask);
   endfunction

   always_comb begin
      case (size)
         2'b00:   aligned_c = (addr[1:0] == 2'b00);
         2'b01:   aligned_c = ~addr[0];
         2'b10:   aligned_c = 1'b1;
         default: aligned_c = 1'b0;
      endcase
   end

   // Next state and next registered outputs.
   always_comb begin
      state_n      = state;
      load_c       = 1'b0;
      mem_addr_n   = mem_addr;
      mem_wr_n     = 1'b0;
      mem_wdata_n  = '0;
      done_n       = 1'b0;
      misaligned_n = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               load_c     = 1'b1;
               mem_addr_n = {addr[AW-1:2], 2'b00};
               if (!aligned_c) begin
                  state_n      = DONE;
                  done_n       = 1'b1;
                  misaligned_n = 1'b1;
               end else if (size == 2'b00) begin
                  state_n     = WRITE;
                  mem_wr_n    = 1'b1;
                  mem_wdata_n = data;
               end else begin
                  state_n = RD_ADDR;
               end
            end
         end
         RD_ADDR: state_n = RD_WAIT;
         RD_WAIT: begin
            // Read word is captured, merged, on the edge leaving RD_WAIT.
            state_n     = WRITE;
            mem_wr_n    = 1'b1;
            mem_wdata_n = merge(mem_rdata, data_q, off_q, half_q);
         end
         WRITE: begin
            state_n = DONE;
            done_n  = 1'b1;
         end
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         off_q      <= '0;
         half_q     <= 1'b0;
         data_q     <= '0;
         mem_addr   <= '0;
         mem_wr     <= 1'b0;
         mem_wdata  <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         misaligned <= 1'b0;
      end else begin
         state      <= state_n;
         mem_addr   <= mem_addr_n;
         mem_wr     <= mem_wr_n;
         mem_wdata  <= mem_wdata_n;
         busy       <= (state_n != IDLE);
         done       <= done_n;
         misaligned <= misaligned_n;
         if (load_c) begin
            off_q  <= addr[1:0];
            half_q <= (size == 2'b01);
            data_q <= data;
         end
      end
   end

endmodule

// File: tb/tb_store_sequencer.sv
// Directed self-checking bench for store_sequencer with a small word memory.
module tb_store_sequencer;

   logic        clk = 1'b0;
   logic        reset, start;
   logic [1:0]  size;
   logic [31:0] addr, data, mem_rdata, mem_addr, mem_wdata;
   logic        mem_wr, busy, done, misaligned;

   logic [31:0] mem [0:255];
   int          wr_count = 0;
   int          total = 0;
   int          bad = 0;

   store_sequencer dut (
      .clk(clk), .reset(reset), .start(start), .size(size), .addr(addr),
      .data(data), .mem_rdata(mem_rdata), .mem_addr(mem_addr), .mem_wr(mem_wr),
      .mem_wdata(mem_wdata), .busy(busy), .done(done), .misaligned(misaligned)
   );

   always #5 clk = ~clk;

   assign mem_rdata = mem[mem_addr[9:2]];

   always @(posedge clk) begin
      if (mem_wr) begin
         mem[mem_addr[9:2]] <= mem_wdata;
         wr_count <= wr_count + 1;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic req(input logic [1:0] s, input logic [31:0] a, input logic [31:0] d);
      start = 1'b1; size = s; addr = a; data = d;
      step();
      start = 1'b0;
   endtask

   int          base;
   logic [9:0]  done_seen;

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 32'h0;
      reset = 1'b1; start = 1'b0; size = 2'b00; addr = 32'h0; data = 32'h0;
      #1;
      step(); step();
      check("rst_addr", mem_addr, 32'h0);
      check("rst_wr", 32'(mem_wr), 32'h0);
      check("rst_wdata", mem_wdata, 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_done", 32'({done, misaligned}), 32'h0);
      reset = 1'b0;
      step();

      // sb
      mem[8'h40] = 32'hAABBCCDD;
      base = wr_count;
      req(2'b10, 32'h102, 32'h12345678);
      check("sb_rdaddr_busy", 32'(busy), 32'h1);
      check("sb_rdaddr_addr", mem_addr, 32'h100);
      check("sb_rdaddr_wr", 32'(mem_wr), 32'h0);
      step();
      check("sb_rdwait_wr", 32'(mem_wr), 32'h0);
      step();
      check("sb_write_wr", 32'(mem_wr), 32'h1);
      check("sb_write_data", mem_wdata, 32'hAA78CCDD);
      step();
      check("sb_done", 32'({done, misaligned, mem_wr}), 32'h4);
      check("sb_done_wdata", mem_wdata, 32'h0);
      step();
      check("sb_idle_busy", 32'(busy), 32'h0);
      check("sb_mem", mem[8'h40], 32'hAA78CCDD);
      check("sb_wrcnt", 32'(wr_count - base), 32'h1);

      // sh
      mem[8'h40] = 32'hAABBCCDD;
      base = wr_count;
      req(2'b01, 32'h102, 32'h0000BEEF);
      step(); step();
      check("sh_write_data", mem_wdata, 32'hBEEFCCDD);
      step();
      check("sh_done", 32'(done), 32'h1);
      step();
      check("sh_mem", mem[8'h40], 32'hBEEFCCDD);
      check("sh_wrcnt", 32'(wr_count - base), 32'h1);

      // sw
      base = wr_count;
      req(2'b00, 32'h104, 32'hCAFEF00D);
      check("sw_write_wr", 32'(mem_wr), 32'h1);
      check("sw_write_addr", mem_addr, 32'h104);
      check("sw_write_data", mem_wdata, 32'hCAFEF00D);
      step();
      check("sw_done", 32'({done, misaligned}), 32'h2);
      step();
      check("sw_mem", mem[8'h41], 32'hCAFEF00D);
      check("sw_wrcnt", 32'(wr_count - base), 32'h1);

      // misaligned half, word and reserved size
      base = wr_count;
      req(2'b01, 32'h101, 32'h11111111);
      check("mis_h_flags", 32'({done, misaligned, mem_wr}), 32'h6);
      check("mis_h_addr", mem_addr, 32'h100);
      step();
      check("mis_h_idle", 32'(busy), 32'h0);
      req(2'b00, 32'h102, 32'h22222222);
      check("mis_w_flags", 32'({done, misaligned, mem_wr}), 32'h6);
      step();
      req(2'b11, 32'h100, 32'h33333333);
      check("mis_r_flags", 32'({done, misaligned, mem_wr}), 32'h6);
      step();
      check("mis_wrcnt", 32'(wr_count - base), 32'h0);

      // reset during RD_WAIT
      mem[8'h40] = 32'hAABBCCDD;
      base = wr_count;
      req(2'b10, 32'h102, 32'h12345678);
      step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("rst_mid_busy", 32'(busy), 32'h0);
      check("rst_mid_addr", mem_addr, 32'h0);
      for (int i = 0; i < 10; i++) step();
      check("rst_mid_wrcnt", 32'(wr_count - base), 32'h0);
      check("rst_mid_mem", mem[8'h40], 32'hAABBCCDD);

      // start while busy is ignored
      base = wr_count;
      req(2'b10, 32'h102, 32'h12345678);
      start = 1'b1; size = 2'b00; addr = 32'h200; data = 32'hFFFFFFFF;
      step();
      start = 1'b0;
      step();
      check("busy_ign_addr", mem_addr, 32'h100);
      check("busy_ign_data", mem_wdata, 32'hAA78CCDD);
      step(); step();
      check("busy_ign_mem", mem[8'h40], 32'hAA78CCDD);
      check("busy_ign_other", mem[8'h80], 32'h0);
      check("busy_ign_wrcnt", 32'(wr_count - base), 32'h1);

      // start held high: byte stores complete every 5 cycles
      mem[8'h40] = 32'hAABBCCDD;
      base = wr_count;
      done_seen = '0;
      start = 1'b1; size = 2'b10; addr = 32'h102; data = 32'h12345678;
      for (int i = 0; i < 10; i++) begin
         step();
         done_seen[i] = done;
      end
      start = 1'b0;
      for (int i = 0; i < 6; i++) step();
      check("b2b_done_pattern", 32'(done_seen), 32'h108);
      check("b2b_wrcnt", 32'(wr_count - base), 32'h2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
